cfg_loader: RTL and testbench
=============================

// Module: cfg_loader
// PURPOSE
//  Streams a configuration bitstream (e.g. global_mux, ptbitmap_mux images) into a shadow
//  register, checks framing, then commits it atomically to cfg_q, which drives the device
//  config mux inputs. Sits between the test/programming harness and the atf1502 fabric.
//  Old config stays live until a complete, valid image commits (double-buffered).
// PARAMETERS
//  CFG_BITS  46  configuration image width (cfg_q[0:CFG_BITS-1])
//  WORD_W    8   input word width; NWORDS = ceil(CFG_BITS/WORD_W) data words per image
// PORTS
//  clk        in   1         single clock, all logic rising-edge
//  rst        in   1         synchronous, active-high reset
//  start      in   1         begin new load; honoured only in IDLE or ERR
//  abort      in   1         discard load in progress, return to IDLE
//  s_valid    in   1         input word valid
//  s_ready    out  1         loader accepts word (transfer = s_valid & s_ready)
//  s_data     in   WORD_W    input word, MSB first
//  s_last     in   1         marks final word of image
//  busy       out  1         high in LOAD/COMMIT (and CHECK when CRC compiled in)
//  done       out  1         one-cycle pulse on commit
//  err        out  1         sticky framing/CRC error, cleared by start or rst
//  cfg_valid  out  1         cfg_q holds a committed image
//  cfg_q      out  CFG_BITS  committed configuration, bit 0 = first bit received
// BEHAVIOUR
//  - Reset: state=IDLE; s_ready=0, busy=0, done=0, err=0, cfg_valid=0, cfg_q=0, shadow=0, count=0.
//  - States: IDLE -> LOAD (start) -> [CHECK] -> COMMIT -> IDLE; any framing fault -> ERR.
//  - IDLE: s_ready=0; start -> LOAD, count=0, err=0.
//  - LOAD: s_ready=1. Each transfer packs s_data MSB first into shadow[count*WORD_W ..];
//    bits beyond CFG_BITS in final data word are padding, ignored. count increments per word.
//  - Framing: s_last on word NWORDS (CRC build: word NWORDS+1) is legal; s_last earlier -> ERR;
//    last legal word without s_last -> ERR. ERR entered the edge after offending transfer.
//  - COMMIT: one cycle; at its closing edge cfg_q<=shadow, cfg_valid<=1, done=1 for the
//    following cycle, state->IDLE. cfg_q updates 2 edges after final-word transfer edge.
//  - ERR: s_ready=0, err=1, cfg_q/cfg_valid unchanged; start -> LOAD (err cleared).
//  - abort: in LOAD/CHECK -> IDLE next edge, shadow discarded, cfg_q unchanged, no err;
//    abort beats a same-cycle final-word transfer (no commit). Ignored in IDLE/COMMIT/ERR.
//  - start while busy: ignored. start and abort together in IDLE: start wins.
//  - rst mid-load: everything to reset values, including cfg_q (config lost).
//  - count width = clog2(NWORDS+2); never wraps, saturates via ERR.
// CONFIGURATION
//  CFG_LOADER_CRC_EN defined: one extra word follows data words carrying CRC-8
//  (poly 0x07, init 0x00, MSB first) over all data words as sent incl. padding (WORD_W=8 only);
//  s_last must be on that word. LOAD -> CHECK (1 cycle compare) -> COMMIT on match, ERR
//  on mismatch. Undefined: no CHECK state, s_last on final data word, no CRC logic.
// STRUCTURE
//  - cfg_pkg: state encoding (IDLE, LOAD, CHECK, COMMIT, ERR), CRC8_POLY, CRC8_INIT, clog2 fn.
//  - Sub-module cfg_crc8: per-word serial-parallel CRC-8 update (clr, en, din, crc);
//    instantiated only under CFG_LOADER_CRC_EN.
//  - Top: FSM, word counter, shadow shift register, cfg_q commit register.
// TESTING
//  1 rst; start; 6 words A5 5A FF 00 C3 3C(last) -> done 1 cycle, cfg_q bits = 46 MSB-first
//    bits of stream, cfg_valid=1, err=0.
//  2 s_last on 3rd word -> err=1, state ERR, cfg_q keeps previous image, no done.
//  3 6th word without s_last -> err=1; then start + valid image -> err cleared, commit ok.
//  4 abort coinciding with 6th word transfer -> IDLE, no done, cfg_q unchanged.
//  5 s_valid toggled randomly (backpressure-free gaps) -> same cfg_q as test 1; start
//    pulsed mid-LOAD ignored.
//  6 CRC_EN: append correct CRC-8 -> commit; flip one CRC bit -> err=1, cfg_q unchanged.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration loader: FSM state encoding,
// CRC-8 constants and small elaboration-time helpers.
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERR    = 3'd4
    } cfg_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Bits needed to hold values 0 .. value-1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Advance a CRC-8 by one byte, most significant bit first
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ din[i])
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            else
                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/cfg_loader_crc8.sv
// Word-at-a-time CRC-8 accumulator over the data words of an image.
// Only exists when CFG_LOADER_CRC_EN is defined.
`ifdef CFG_LOADER_CRC_EN
module cfg_crc8
    import cfg_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    // Restart on a new load, fold in each accepted data word
    always_ff @(posedge clk) begin
        if (rst || clr)
            crc <= CRC8_INIT;
        else if (en)
            crc <= crc8_update(crc, din);
    end

endmodule
`endif

// File: rtl/cfg_loader.sv
// Configuration loader: streams an image into a shadow register, checks its
// framing and commits it atomically to cfg_q. The previous image stays live
// until a complete, well-framed image commits.
// Optional feature macro: CFG_LOADER_CRC_EN adds a trailing CRC-8 word and a
// CHECK state between LOAD and COMMIT.
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int CFG_BITS = 46,
    parameter int WORD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_last,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                cfg_valid,
    output logic [CFG_BITS-1:0] cfg_q
);

    localparam int NWORDS = (CFG_BITS + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = clog2(NWORDS + 2);

`ifdef CFG_LOADER_CRC_EN
    // The CRC word follows the data words and must carry s_last
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NWORDS);
    localparam cfg_state_e       AFTER_LOAD = ST_CHECK;
`else
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NWORDS - 1);
    localparam cfg_state_e       AFTER_LOAD = ST_COMMIT;
`endif

    cfg_state_e          state;
    cfg_state_e          state_nxt;
    logic [CNT_W-1:0]    count;
    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] shadow_nxt;
    logic                in_load;
    logic                start_acc;
    logic                xfer;
    logic                data_xfer;

    assign in_load   = (state == ST_LOAD);
    assign start_acc = start && (state == ST_IDLE || state == ST_ERR);
    // An aborted cycle never counts as a transfer, so abort beats the last word
    assign xfer      = in_load && s_valid && !abort;
    assign data_xfer = xfer && (count < CNT_W'(NWORDS));

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] crc_calc;
    logic [7:0] crc_rx;
    logic       crc_ok;

    cfg_crc8 u_crc8 (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (data_xfer),
        .din (s_data),
        .crc (crc_calc)
    );

    // Capture the received CRC word for the one-cycle compare in CHECK
    always_ff @(posedge clk) begin
        if (rst)
            crc_rx <= '0;
        else if (xfer && count == CNT_W'(NWORDS))
            crc_rx <= s_data;
    end

    assign crc_ok = (crc_calc == crc_rx);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state, framing decisions and status outputs
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (abort)
                    state_nxt = ST_IDLE;
                else if (xfer) begin
                    if (count == LAST_IDX)
                        state_nxt = s_last ? AFTER_LOAD : ST_ERR;
                    else if (s_last)
                        state_nxt = ST_ERR;
                end
            end
`ifdef CFG_LOADER_CRC_EN
            ST_CHECK: begin
                busy = 1'b1;
                if (abort)
                    state_nxt = ST_IDLE;
                else
                    state_nxt = crc_ok ? ST_COMMIT : ST_ERR;
            end
`endif
            ST_COMMIT: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                err = 1'b1;
                if (start)
                    state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Place the current word MSB first at bit count*WORD_W; padding bits
    // past CFG_BITS have no slot and are dropped
    always_comb begin
        shadow_nxt = shadow;
        if (data_xfer) begin
            for (int b = 0; b < CFG_BITS; b++) begin
                if (int'(count) == b / WORD_W)
                    shadow_nxt[b] = s_data[WORD_W-1-(b % WORD_W)];
            end
        end
    end

    // Word counter, shadow image, committed image and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            shadow    <= '0;
            cfg_q     <= '0;
            cfg_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (start_acc)
                count <= '0;
            else if (xfer)
                count <= count + 1'b1;
            shadow <= shadow_nxt;
            done   <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                cfg_q     <= shadow;
                cfg_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Randomized self-checking bench for cfg_loader with a transaction-level
// reference model of the expected outputs.
module tb_cfg_loader;

    localparam int CFG_BITS = 46;
    localparam int WORD_W   = 8;
    localparam int NWORDS   = 6;
`ifdef CFG_LOADER_CRC_EN
    localparam bit CRC  = 1'b1;
    localparam int LAST = NWORDS;
`else
    localparam bit CRC  = 1'b0;
    localparam int LAST = NWORDS - 1;
`endif

    logic                clk;
    logic                rst;
    logic                start;
    logic                abort;
    logic                s_valid;
    logic                s_ready;
    logic [WORD_W-1:0]   s_data;
    logic                s_last;
    logic                busy;
    logic                done;
    logic                err;
    logic                cfg_valid;
    logic [CFG_BITS-1:0] cfg_q;

    cfg_loader #(.CFG_BITS(CFG_BITS), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cfg_valid (cfg_valid),
        .cfg_q     (cfg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs, updated by the driver just after each active edge
    logic                exp_ready;
    logic                exp_busy;
    logic                exp_done;
    logic                exp_err;
    logic                exp_valid;
    logic [CFG_BITS-1:0] exp_q;
    bit                  mon_en;

    int n_checks;
    int n_pass;

    logic [7:0] wbuf [8];

    localparam logic [CFG_BITS-1:0] IMG1 = 46'h3CC3_00FF_5AA5;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endtask

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            check("s_ready",   64'(s_ready),   64'(exp_ready));
            check("busy",      64'(busy),      64'(exp_busy));
            check("done",      64'(done),      64'(exp_done));
            check("err",       64'(err),       64'(exp_err));
            check("cfg_valid", 64'(cfg_valid), 64'(exp_valid));
            check("cfg_q",     64'(cfg_q),     64'(exp_q));
        end
    end

    // Image = first CFG_BITS bits of the concatenated stream, bit 0 first
    function automatic logic [CFG_BITS-1:0] image_of();
        logic [47:0]         stream;
        logic [CFG_BITS-1:0] img;
        stream = {wbuf[0], wbuf[1], wbuf[2], wbuf[3], wbuf[4], wbuf[5]};
        for (int b = 0; b < CFG_BITS; b++)
            img[b] = stream[47-b];
        return img;
    endfunction

    function automatic logic [7:0] crc8_bytes(input logic [7:0] bytes [$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (bytes[i]) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ bytes[i][j];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] data_crc();
        logic [7:0] q [$];
        for (int i = 0; i < NWORDS; i++)
            q.push_back(wbuf[i]);
        return crc8_bytes(q);
    endfunction

    task automatic set_img1();
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hFF;
        wbuf[3] = 8'h00; wbuf[4] = 8'hC3; wbuf[5] = 8'h3C;
        wbuf[6] = data_crc();
        wbuf[7] = 8'h00;
    endtask

    task automatic set_random();
        for (int i = 0; i < 8; i++)
            wbuf[i] = 8'($urandom);
        wbuf[6] = data_crc();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load attempt: start, then up to n words. last_idx / abort_idx of -1
    // mean never. Expectations follow the framing rules word by word.
    task automatic do_load(input int n, input int last_idx, input int abort_idx,
                           input bit gaps, input bit start_abort);
        logic [CFG_BITS-1:0] img;
        bit                  crc_good;
        img      = image_of();
        crc_good = (wbuf[NWORDS] == data_crc());
        start = 1'b1;
        abort = start_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        exp_ready = 1'b1;
        exp_busy  = 1'b1;
        exp_err   = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    s_valid = 1'b0;
                    start   = 1'($urandom_range(0, 1));
                    s_data  = 8'($urandom);
                    tick();
                    start = 1'b0;
                end
            end
            s_valid = 1'b1;
            s_data  = wbuf[k];
            s_last  = (k == last_idx);
            abort   = (k == abort_idx);
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
            abort   = 1'b0;
            if (k == abort_idx) begin
                exp_ready = 1'b0;
                exp_busy  = 1'b0;
                return;
            end
            if (k == last_idx || k == LAST) begin
                exp_ready = 1'b0;
                if (!(k == last_idx && k == LAST)) begin
                    exp_busy = 1'b0;
                    exp_err  = 1'b1;
                    return;
                end
                if (CRC) begin
                    tick();
                    if (!crc_good) begin
                        exp_busy = 1'b0;
                        exp_err  = 1'b1;
                        return;
                    end
                end
                tick();
                exp_q     = img;
                exp_valid = 1'b1;
                exp_done  = 1'b1;
                exp_busy  = 1'b0;
                tick();
                exp_done = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q [$];
        int         sc;
        int         r;

        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_valid = 1'b0;
        exp_q     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Pin the model against hand-computed values
        for (int i = 0; i < 9; i++)
            q.push_back(8'(8'h31 + i));
        check("model_crc_check", 64'(crc8_bytes(q)), 64'h00F4);
        set_img1();
        check("model_img1", 64'(image_of()), 64'(IMG1));
        tick();

        // 1: well-formed image
        set_img1();
        do_load(LAST + 1, LAST, -1, 1'b0, 1'b0);
        check("t1_cfg_q_literal", 64'(cfg_q), 64'(IMG1));
        repeat (2) tick();

        // 2: early s_last -> error, image kept
        set_random();
        do_load(3, 2, -1, 1'b0, 1'b0);
        repeat (2) tick();
        check("t2_cfg_q_kept", 64'(cfg_q), 64'(IMG1));
        check("t2_err_literal", 64'(err), 64'h1);

        // 3: missing s_last -> error, then recovery
        set_random();
        do_load(LAST + 1, -1, -1, 1'b0, 1'b0);
        tick();
        set_random();
        do_load(LAST + 1, LAST, -1, 1'b0, 1'b0);
        check("t3_err_cleared", 64'(err), 64'h0);
        tick();

        // 4: abort on the final word -> no commit
        set_random();
        do_load(LAST + 1, LAST, LAST, 1'b0, 1'b0);
        repeat (2) tick();

        // abort alone in IDLE is ignored; start with abort in IDLE starts
        abort = 1'b1;
        repeat (3) tick();
        abort = 1'b0;
        set_random();
        do_load(LAST + 1, LAST, -1, 1'b0, 1'b1);
        tick();

        // 5: gaps and stray start pulses give the same image as test 1
        set_img1();
        do_load(LAST + 1, LAST, -1, 1'b1, 1'b0);
        check("t5_cfg_q_literal", 64'(cfg_q), 64'(IMG1));
        tick();

        // reset mid-load loses the committed configuration
        set_random();
        do_load(3, -1, -1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
        exp_err   = 1'b0;
        exp_valid = 1'b0;
        exp_q     = '0;
        check("rst_cfg_q_literal", 64'(cfg_q), 64'h0);
        tick();

`ifdef CFG_LOADER_CRC_EN
        // 6: good CRC commits, one flipped CRC bit errors and keeps the image
        set_img1();
        do_load(LAST + 1, LAST, -1, 1'b0, 1'b0);
        check("t6_crc_commit", 64'(cfg_q), 64'(IMG1));
        tick();
        set_random();
        wbuf[NWORDS] = wbuf[NWORDS] ^ 8'h10;
        do_load(LAST + 1, LAST, -1, 1'b0, 1'b0);
        tick();
        check("t6_crc_err", 64'(err), 64'h1);
        check("t6_crc_kept", 64'(cfg_q), 64'(IMG1));
`endif

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            set_random();
            sc = $urandom_range(0, CRC ? 4 : 3);
            case (sc)
                1: begin
                    r = $urandom_range(0, LAST - 1);
                    do_load(r + 1, r, -1, 1'($urandom_range(0, 1)), 1'b0);
                end
                2: do_load(LAST + 1, -1, -1, 1'($urandom_range(0, 1)), 1'b0);
                3: begin
                    r = $urandom_range(0, LAST);
                    do_load(LAST + 1, LAST, r, 1'($urandom_range(0, 1)), 1'b0);
                end
                4: begin
                    wbuf[NWORDS] = wbuf[NWORDS] ^ 8'(1 << $urandom_range(0, 7));
                    do_load(LAST + 1, LAST, -1, 1'($urandom_range(0, 1)), 1'b0);
                end
                default: do_load(LAST + 1, LAST, -1, 1'($urandom_range(0, 1)), 1'b0);
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
